// File: rtl/ra_sdr_array_subsys.sv
// 64x72 2R1W SDR register file with a 16-bit configuration register and an optional
// BIST engine that takes over the array ports (enabled by defining RA_SDR_BIST_EN).
// All buses use big-endian numbering: bit 0 is the MSB.
module ra_sdr_array_subsys #(
    parameter int                   CFG_WIDTH = 16,
    parameter logic [CFG_WIDTH-1:0] CFG_INIT  = {CFG_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wr,
    input  logic [0:CFG_WIDTH-1] cfg_dat,
    output logic [0:CFG_WIDTH-1] cfg,
    input  logic [0:31]          bist_ctl,
    output logic [0:31]          bist_status,
    input  logic                 rd_enb_0,
    input  logic [0:5]           rd_adr_0,
    output logic [0:72-1]        rd_dat_0,
    input  logic                 rd_enb_1,
    input  logic [0:5]           rd_adr_1,
    output logic [0:72-1]        rd_dat_1,
    input  logic                 wr_enb_0,
    input  logic [0:5]           wr_adr_0,
    input  logic [0:71]          wr_dat_0
);

    localparam int DEPTH = 64;
    localparam int WIDTH = 72;
    localparam int AW    = 6;

    logic [0:CFG_WIDTH-1] r_cfg;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg <= CFG_INIT;
        end else if (cfg_wr) begin
            r_cfg <= cfg_dat;
        end
    end

    assign cfg = r_cfg;

    logic            w_arr_wr_enb;
    logic [0:AW-1]   w_arr_wr_adr;
    logic [0:WIDTH-1] w_arr_wr_dat;
    logic            w_arr_rd_enb_0;
    logic [0:AW-1]   w_arr_rd_adr_0;
    logic            w_arr_rd_enb_1;
    logic [0:AW-1]   w_arr_rd_adr_1;

    logic [0:DEPTH-1][0:WIDTH-1] r_mem;
    logic [0:WIDTH-1]            r_rd_dat_0;
    logic [0:WIDTH-1]            r_rd_dat_1;

    // NOTE: the storage array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_arr_wr_enb) begin
            r_mem[w_arr_wr_adr] <= w_arr_wr_dat;
        end
    end

    // Reads sample the array at the same edge as a write, so a colliding read sees old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_dat_0 <= '0;
            r_rd_dat_1 <= '0;
        end else begin
            if (w_arr_rd_enb_0) begin
                r_rd_dat_0 <= r_mem[w_arr_rd_adr_0];
            end
            if (w_arr_rd_enb_1) begin
                r_rd_dat_1 <= r_mem[w_arr_rd_adr_1];
            end
        end
    end

    assign rd_dat_0 = r_rd_dat_0;
    assign rd_dat_1 = r_rd_dat_1;

`ifdef RA_SDR_BIST_EN

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } bist_state_t;

    function automatic logic [0:WIDTH-1] f_pattern(input logic [0:1] sel, input logic [0:AW-1] adr);
        case (sel)
            2'b00:   return '0;
            2'b01:   return '1;
            2'b10:   return adr[AW-1] ? {9{8'hAA}} : {9{8'h55}};
            default: return {12{adr}};
        endcase
    endfunction

    bist_state_t   r_state;
    logic          r_run_q;
    logic [0:AW-1] r_addr;
    logic [0:1]    r_pat;
    logic          r_cmp_vld;
    logic [0:AW-1] r_cmp_adr_0;
    logic [0:AW-1] r_cmp_adr_1;
    logic          r_done;
    logic          r_fail;
    logic [0:AW-1] r_fail_adr;
    logic [0:7]    r_err_cnt;

    logic w_run;
    logic w_start;
    logic w_mis_0;
    logic w_mis_1;
    logic w_bist_act;
    logic w_busy;
    logic w_unused_ctl;

    assign w_run        = bist_ctl[0];
    assign w_start      = w_run && !r_run_q;
    assign w_unused_ctl = &{1'b0, bist_ctl[3:31]};
    assign w_mis_0      = (r_rd_dat_0 != f_pattern(r_pat, r_cmp_adr_0));
    assign w_mis_1      = (r_rd_dat_1 != f_pattern(r_pat, r_cmp_adr_1));

    // r_run_q resets high so a run bit already set at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_run_q     <= 1'b1;
            r_addr      <= '0;
            r_pat       <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_adr_0 <= '0;
            r_cmp_adr_1 <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_adr  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_run_q   <= w_run;
            r_cmp_vld <= 1'b0;
            if (r_state != S_IDLE && !w_run) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state    <= S_WRITE;
                            r_addr     <= '0;
                            r_pat      <= bist_ctl[1:2];
                            r_done     <= 1'b0;
                            r_fail     <= 1'b0;
                            r_fail_adr <= '0;
                            r_err_cnt  <= '0;
                        end
                    end
                    S_WRITE: begin
                        r_addr <= r_addr + 6'd1;
                        if (r_addr == 6'd63) begin
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        r_cmp_vld   <= 1'b1;
                        r_cmp_adr_0 <= r_addr;
                        r_cmp_adr_1 <= ~r_addr;
                        r_addr      <= r_addr + 6'd1;
                        if (r_addr == 6'd63) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                    default: begin
                    end
                endcase

                if (r_cmp_vld && (w_mis_0 || w_mis_1)) begin
                    r_fail <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (!r_fail) begin
                        r_fail_adr <= w_mis_0 ? r_cmp_adr_0 : r_cmp_adr_1;
                    end
                end
            end
        end
    end

    assign w_bist_act = (r_state != S_IDLE);
    assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);

    assign w_arr_wr_enb   = w_bist_act ? (r_state == S_WRITE) : wr_enb_0;
    assign w_arr_wr_adr   = w_bist_act ? r_addr : wr_adr_0;
    assign w_arr_wr_dat   = w_bist_act ? f_pattern(r_pat, r_addr) : wr_dat_0;
    assign w_arr_rd_enb_0 = w_bist_act ? (r_state == S_READ) : rd_enb_0;
    assign w_arr_rd_adr_0 = w_bist_act ? r_addr : rd_adr_0;
    assign w_arr_rd_enb_1 = w_bist_act ? (r_state == S_READ) : rd_enb_1;
    assign w_arr_rd_adr_1 = w_bist_act ? ~r_addr : rd_adr_1;

    assign bist_status = {w_busy, r_done, r_fail, r_fail_adr, 7'b0, r_err_cnt, 8'b0};

`else

    logic w_unused_ctl;

    assign w_unused_ctl   = &{1'b0, bist_ctl};
    assign w_arr_wr_enb   = wr_enb_0;
    assign w_arr_wr_adr   = wr_adr_0;
    assign w_arr_wr_dat   = wr_dat_0;
    assign w_arr_rd_enb_0 = rd_enb_0;
    assign w_arr_rd_adr_0 = rd_adr_0;
    assign w_arr_rd_enb_1 = rd_enb_1;
    assign w_arr_rd_adr_1 = rd_adr_1;
    assign bist_status    = '0;

`endif

endmodule

// File: tb/tb_ra_sdr_array_subsys.sv
// Directed-vector bench for ra_sdr_array_subsys; BIST scenarios are exercised when
// RA_SDR_BIST_EN is defined, otherwise the bench checks that BIST control is ignored.
module tb_ra_sdr_array_subsys;

    localparam logic [0:71] P55   = 72'h555555555555555555;
    localparam logic [0:71] PAA   = 72'hAAAAAAAAAAAAAAAAAA;
    localparam logic [0:71] P33   = 72'h333333333333333333;
    localparam logic [0:71] P0F   = 72'h0F0F0F0F0F0F0F0F0F;
    localparam logic [0:71] PVAL9 = 72'h0123456789ABCDEF01;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [0:15] cfg_dat;
    logic [0:15] cfg;
    logic [0:31] bist_ctl;
    logic [0:31] bist_status;
    logic        rd_enb_0;
    logic [0:5]  rd_adr_0;
    logic [0:71] rd_dat_0;
    logic        rd_enb_1;
    logic [0:5]  rd_adr_1;
    logic [0:71] rd_dat_1;
    logic        wr_enb_0;
    logic [0:5]  wr_adr_0;
    logic [0:71] wr_dat_0;

    int n_vec = 0;
    int n_err = 0;
    int busy_cyc;

    always #5 clk = ~clk;

    ra_sdr_array_subsys dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_dat     (cfg_dat),
        .cfg         (cfg),
        .bist_ctl    (bist_ctl),
        .bist_status (bist_status),
        .rd_enb_0    (rd_enb_0),
        .rd_adr_0    (rd_adr_0),
        .rd_dat_0    (rd_dat_0),
        .rd_enb_1    (rd_enb_1),
        .rd_adr_1    (rd_adr_1),
        .rd_dat_1    (rd_dat_1),
        .wr_enb_0    (wr_enb_0),
        .wr_adr_0    (wr_adr_0),
        .wr_dat_0    (wr_dat_0)
    );

    task automatic check(input string tag, input logic [0:71] obs, input logic [0:71] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and counts sampled busy cycles, bounded so a stuck FSM cannot hang the bench.
    task automatic run_bist(input logic [0:31] ctl, output int cyc);
        bist_ctl = ctl;
        cyc = 0;
        tick();
        while (bist_status[0] && cyc < 300) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        reset    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_dat  = '0;
        bist_ctl = '0;
        rd_enb_0 = 1'b0;
        rd_adr_0 = '0;
        rd_enb_1 = 1'b0;
        rd_adr_1 = '0;
        wr_enb_0 = 1'b0;
        wr_adr_0 = '0;
        wr_dat_0 = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("reset_cfg", 72'(cfg), 72'(16'hFFFF));
        check("reset_rd0", rd_dat_0, 72'h0);
        check("reset_rd1", rd_dat_1, 72'h0);
        check("reset_status", 72'(bist_status), 72'h0);

        cfg_dat = 16'h1234;
        cfg_wr  = 1'b1;
        tick();
        check("cfg_write", 72'(cfg), 72'(16'h1234));
        cfg_dat = 16'hABCD;
        cfg_wr  = 1'b0;
        tick();
        check("cfg_hold", 72'(cfg), 72'(16'h1234));

        wr_enb_0 = 1'b1;
        wr_adr_0 = 6'd0;
        wr_dat_0 = P55;
        tick();
        for (int a = 2; a <= 8; a += 2) begin
            wr_adr_0 = 6'(a);
            wr_dat_0 = PAA;
            tick();
        end
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 6'd0;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 6'd2;
        tick();
        check("rd0_adr0", rd_dat_0, P55);
        check("rd1_adr2", rd_dat_1, PAA);
        rd_enb_0 = 1'b0;
        rd_adr_0 = 6'd4;
        rd_adr_1 = 6'd8;
        tick();
        check("rd0_hold", rd_dat_0, P55);
        check("rd1_same", rd_dat_1, PAA);
        rd_enb_1 = 1'b0;

        wr_enb_0 = 1'b1;
        wr_adr_0 = 6'd5;
        wr_dat_0 = P33;
        tick();
        wr_dat_0 = P0F;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 6'd5;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 6'd5;
        tick();
        check("collide_rd0_old", rd_dat_0, P33);
        check("collide_rd1_old", rd_dat_1, P33);
        wr_enb_0 = 1'b0;
        tick();
        check("collide_rd0_new", rd_dat_0, P0F);
        check("collide_rd1_new", rd_dat_1, P0F);
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;

`ifdef RA_SDR_BIST_EN
        run_bist(32'hE000_0000, busy_cyc);
        check("pass_busy_cycles", 72'(busy_cyc), 72'd129);
        check("pass_status", 72'(bist_status), 72'(32'h4000_0000));
        bist_ctl = '0;
        tick();
        check("pass_status_idle", 72'(bist_status), 72'(32'h4000_0000));
        rd_enb_0 = 1'b1;
        rd_adr_0 = 6'd5;
        rd_enb_1 = 1'b1;
        rd_adr_1 = 6'd2;
        tick();
        check("pass_mem_adr5", rd_dat_0, 72'h145145145145145145);
        check("pass_mem_adr2", rd_dat_1, 72'h082082082082082082);
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;

        force dut.r_mem[17][0] = 1'b1;
        run_bist(32'h8000_0000, busy_cyc);
        check("fail_busy_cycles", 72'(busy_cyc), 72'd129);
        check("fail_status", 72'(bist_status), 72'(32'h6880_0200));
        check("fail_adr", 72'(bist_status[3:8]), 72'd17);
        check("fail_err_cnt", 72'(bist_status[16:23]), 72'd2);
        release dut.r_mem[17][0];
        bist_ctl = '0;
        tick();

        bist_ctl = 32'hA000_0000;
        repeat (70) tick();
        check("abort_busy", 72'(bist_status), 72'(32'h8000_0000));
        bist_ctl = '0;
        tick();
        check("abort_idle", 72'(bist_status), 72'h0);
`else
        bist_ctl = 32'hE000_0000;
        repeat (5) tick();
        check("nobist_status", 72'(bist_status), 72'h0);
`endif

        wr_enb_0 = 1'b1;
        wr_adr_0 = 6'd9;
        wr_dat_0 = PVAL9;
        tick();
        wr_enb_0 = 1'b0;
        rd_enb_0 = 1'b1;
        rd_adr_0 = 6'd9;
        tick();
        check("func_after_bist", rd_dat_0, PVAL9);
        rd_enb_0 = 1'b0;

        bist_ctl = 32'h8000_0000;
        reset    = 1'b0;
        #2;
        check("async_reset_cfg", 72'(cfg), 72'(16'hFFFF));
        check("async_reset_rd0", rd_dat_0, 72'h0);
        check("async_reset_status", 72'(bist_status), 72'h0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("no_start_at_release", 72'(bist_status), 72'h0);
        bist_ctl = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ra_sdr_array_subsys.md
# ra_sdr_array_subsys

Single-clock (SDR) 64-word × 72-bit register-file subsystem with two read ports and one write port (2R1W), a built-in self-test (BIST) engine that can take over the array ports, and a 16-bit configuration register. The `cfg` output drives an external local clock buffer (LCB) strobe generator. All buses use big-endian bit numbering: bit 0 is the MSB.

## Interface
Parameters:
- `CFG_WIDTH`, 16: width of the configuration register.
- `CFG_INIT`, all ones (16'hFFFF): reset value of the configuration register.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cfg_wr`  in  1: configuration register write enable.
- `cfg_dat`  in  [0:15]: configuration write data.
- `cfg`  out  [0:15]: current configuration register value.
- `bist_ctl`  in  [0:31]: BIST control.
- `bist_status`  out  [0:31]: BIST status.
- `rd_enb_0`, `rd_enb_1`  in  1: functional read enables.
- `rd_adr_0`, `rd_adr_1`  in  [0:5]: functional read addresses.
- `rd_dat_0`, `rd_dat_1`  out  [0:72-1]: registered read data.
- `wr_enb_0`  in  1: functional write enable.
- `wr_adr_0`  in  [0:5]: write address.
- `wr_dat_0`  in  [0:71]: write data.

## Operation
Configuration register:
- Loads `cfg_dat` when `cfg_wr`=1.
- Holds its value otherwise.
- Reset value is `CFG_INIT`.

Array:
- Write: when `wr_enb_0`=1, `mem[wr_adr_0]` is loaded with `wr_dat_0`.
- Read: when `rd_enb_N`=1, `rd_dat_N` is loaded with `mem[rd_adr_N]`. When `rd_enb_N`=0, `rd_dat_N` holds its previous value.
- Both read ports are independent and may access the same address.
- A read and write to the same address in the same cycle returns the old data (read-before-write).
- Array contents are not reset. `rd_dat_0` and `rd_dat_1` reset to 0.

BIST control bits:
- `bist_ctl[0]`: run.
- `bist_ctl[1:2]`: pattern select.
  - 00: all zeros.
  - 01: all ones.
  - 10: checkerboard, 72'h55…55 at even addresses and 72'hAA…AA at odd addresses.
  - 11: address-in-data, i.e. the address replicated 12 times.
- `bist_ctl[3:31]`: ignored.

BIST port muxing:
- While the FSM is not IDLE, the BIST drives all array ports and the functional inputs are ignored.
- In IDLE, the functional ports pass straight through to the array.

BIST state machine:
- IDLE → WRITE on a rising edge of `bist_ctl[0]`. Entering WRITE clears done, fail, fail address and error count.
- WRITE: 64 cycles. Writes pattern(a) to address a, for a = 0..63.
- READ: 64 cycles. Port 0 reads address a; port 1 reads address 63−a.
- COMPARE: each read result is checked one cycle after it is issued. DRAIN is one extra cycle for the final compare.
- DONE: entered after DRAIN. Stays in DONE until `bist_ctl[0]`=0, then → IDLE.
- Deasserting `bist_ctl[0]` in any state forces IDLE next cycle. Done is not set after an abort.

Mismatch handling:
- A compare cycle where either port mismatches its expected pattern sets fail (sticky).
- The error count increments by 1 per mismatching cycle and saturates at 255.
- The first failing compare records the fail address: port 0's address if port 0 mismatched, otherwise port 1's.

`bist_status` fields:
- [0]: busy (state ≠ IDLE and ≠ DONE).
- [1]: done.
- [2]: fail.
- [3:8]: first fail address.
- [9:15]: 0.
- [16:23]: error count.
- [24:31]: 0.
- Status values are retained in IDLE until the next start.

## Timing
- Write at edge N is visible to a read issued at edge N+1. Read data appears one cycle after the enable/address edge.
- BIST run from start edge S:
  - WRITE occupies S+1..S+64.
  - READ issues at S+65..S+128.
  - DRAIN occurs at S+129.
  - done=1 from S+130.
- Reset asserted at any time asynchronously does the following:
  - forces IDLE;
  - clears all status fields and `rd_dat_*`;
  - sets `cfg` to `CFG_INIT`.
- `bist_ctl[0]` already high when reset releases does not start a run; a fresh 0→1 edge is required.

## Configuration
- `RA_SDR_BIST_EN`
  - Defined: BIST engine and port mux are included as described above.
  - Undefined: functional ports connect directly to the array, `bist_ctl` is ignored, and `bist_status` is constantly 0.

## Test plan
- Reset release: `cfg`=16'hFFFF, `rd_dat_0`=`rd_dat_1`=0, `bist_status`=0. Write `cfg_dat`=16'h1234 with `cfg_wr` → `cfg`=16'h1234 next cycle.
- Functional write/read: write 72'h55…55 to address 0, then 72'hAA…AA to 2, 4, 6 and 8. Read address 0 on port 0 and address 2 on port 1 → 55…55 and AA…AA one cycle after the read edge.
- Same-cycle collision: write 72'h0F…0F to address 5 while reading address 5 → old value returned, new value on the next read.
- BIST pass, pattern 11: raise `bist_ctl[0]` → busy for 129 cycles, then `bist_status`=done=1, fail=0, count=0. Functional contents are overwritten.
- BIST fail: force array bit 0 of address 17 stuck at 1 (bench `force`), run pattern 00 → fail=1, fail address=17, count=2 (once on port 0, once on port 1).
- Abort: drop `bist_ctl[0]` during READ → IDLE next cycle, done=0, functional ports operate again.
